// File: rtl/fsmc_pkg.sv
// Shared constants and types for the FSMC mailbox: channel map, CTRL bit
// positions and the accelerator handshake state encoding.
package fsmc_pkg;

   localparam int CH_ADDR   = 0;
   localparam int CH_DATA   = 1;
   localparam int CH_CTRL   = 2;
   localparam int CH_RESULT = 3;

   localparam int CTRL_START = 0;
   localparam int CTRL_CLR   = 1;
   localparam int CTRL_ADV   = 2;

   typedef enum logic [1:0] {
      MB_IDLE  = 2'd0,
      MB_ARMED = 2'd1,
      MB_RUN   = 2'd2,
      MB_DONE  = 2'd3
   } mb_state_t;

endpackage

// File: rtl/fsmc_dpram.sv
// Simple dual-port synchronous RAM: port A read/write, port B read-only,
// both with one cycle of read latency and read-old-data on a same-address write.
module fsmc_dpram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  a_we_i,
   input  logic [ADDR_WIDTH-1:0] a_addr_i,
   input  logic [DATA_WIDTH-1:0] a_wdata_i,
   output logic [DATA_WIDTH-1:0] a_rdata_o,
   input  logic [ADDR_WIDTH-1:0] b_addr_i,
   output logic [DATA_WIDTH-1:0] b_rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   // NOTE: the array has no reset so it maps onto block RAM; contents start undefined.
   always_ff @(posedge clk) begin
      if (a_we_i) begin
         mem_q[a_addr_i] <= a_wdata_i;
      end
      a_rdata_o <= mem_q[a_addr_i];
      b_rdata_o <= mem_q[b_addr_i];
   end

endmodule

// File: rtl/fsmc_mailbox.sv
// MCU-side mailbox behind the FSMC bus interface: pointer-addressed shared
// buffer, start/done handshake with a fabric accelerator, status and result.
module fsmc_mailbox
   import fsmc_pkg::*;
#(
   parameter int  DATA_WIDTH = 16,
   parameter int  CS_WIDTH   = 2,
   parameter int  BUF_DEPTH  = 256,
   localparam int PTR_WIDTH  = $clog2(BUF_DEPTH),
   localparam int NUM_CH     = 1 << CS_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CH-1:0]     host_cs,
   input  logic                  host_is_read,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  fab_start,
   input  logic [PTR_WIDTH-1:0]  fab_raddr,
   output logic [DATA_WIDTH-1:0] fab_rdata,
   input  logic                  fab_done,
   input  logic [DATA_WIDTH-1:0] fab_result
);

   logic [NUM_CH-1:0]     prev_cs_q;
   logic                  prev_is_read_q;
   logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
   mb_state_t             state_q, state_d;
   mb_state_t             eff_state;

   logic [NUM_CH-1:0]     cs_fall;
   logic                  wr_ok;
   logic                  evt_addr, evt_data, evt_ctrl;
   logic                  busy;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // A write completes when a single selected channel deselects after a write access.
   assign wr_ok    = $onehot(prev_cs_q) && !prev_is_read_q;
   assign cs_fall  = prev_cs_q & ~host_cs;
   assign evt_addr = wr_ok && cs_fall[CH_ADDR];
   assign evt_data = wr_ok && cs_fall[CH_DATA];
   assign evt_ctrl = wr_ok && cs_fall[CH_CTRL];

   assign busy = (state_q == MB_ARMED) || (state_q == MB_RUN);

   // A same-cycle fab_done is applied first; CTRL commands then see DONE.
   assign eff_state = (state_q == MB_RUN && fab_done) ? MB_DONE : state_q;

   fsmc_dpram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (PTR_WIDTH)
   ) u_dpram (
      .clk       (clk),
      .a_we_i    (ram_we),
      .a_addr_i  (ptr_q),
      .a_wdata_i (host_wdata),
      .a_rdata_o (ram_rdata),
      .b_addr_i  (fab_raddr),
      .b_rdata_o (fab_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= MB_IDLE;
         prev_cs_q      <= '0;
         prev_is_read_q <= 1'b0;
         ptr_q          <= '0;
         err_q          <= 1'b0;
         result_q       <= '0;
         host_rdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         prev_cs_q      <= host_cs;
         prev_is_read_q <= host_is_read;
         ptr_q          <= ptr_d;
         err_q          <= err_d;
         result_q       <= result_d;
         host_rdata_q   <= host_rdata_d;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = eff_state;
      if (eff_state == MB_ARMED) begin
         state_d = MB_RUN;
      end
      if (evt_ctrl) begin
         if (host_wdata[CTRL_CLR] && state_d == MB_DONE) begin
            state_d = MB_IDLE;
         end
         if (host_wdata[CTRL_START] && (state_d == MB_IDLE || state_d == MB_DONE)) begin
            state_d = MB_ARMED;
         end
      end
   end

   always_comb begin
      fab_start  = (state_q == MB_ARMED);
      host_rdata = host_rdata_q;
   end

   always_comb begin
      ptr_d    = ptr_q;
      err_d    = err_q;
      result_d = result_q;
      ram_we   = 1'b0;
      if (state_q == MB_RUN && fab_done) begin
         result_d = fab_result;
      end
      if (evt_addr) begin
         ptr_d = host_wdata[PTR_WIDTH-1:0];
      end
      if (evt_data) begin
         if (busy) begin
            err_d = 1'b1;
         end else begin
            ram_we = 1'b1;
            ptr_d  = ptr_q + PTR_WIDTH'(1);
         end
      end
      if (evt_ctrl) begin
         if (host_wdata[CTRL_ADV]) begin
            ptr_d = ptr_q + PTR_WIDTH'(1);
         end
         if (host_wdata[CTRL_CLR]) begin
            err_d = 1'b0;
         end
         if (host_wdata[CTRL_START] && (eff_state == MB_ARMED || eff_state == MB_RUN)) begin
            err_d = 1'b1;
         end
      end
   end

   // DATA reads add a cycle because the RAM output is itself registered.
   always_comb begin
      host_rdata_d = '0;
      if ($onehot(host_cs)) begin
         if (host_cs[CH_ADDR]) begin
            host_rdata_d = {{(DATA_WIDTH-PTR_WIDTH){1'b0}}, ptr_q};
         end
         if (host_cs[CH_DATA]) begin
            host_rdata_d = ram_rdata;
         end
         if (host_cs[CH_CTRL]) begin
            host_rdata_d = {{(DATA_WIDTH-3){1'b0}}, err_q, state_q};
         end
         if (host_cs[CH_RESULT]) begin
            host_rdata_d = result_q;
         end
      end
   end

endmodule
